// File: rtl/bitstream_decoder.sv
// Windowed stochastic-bitstream decoder: counts ones per channel over 2^WINDOW_LOG2 cycles.
// Optional bipolar output encoding is enabled with `define BITSTREAM_DECODER_BIPOLAR_EN.
module bitstream_decoder #(
    parameter int CHANNELS      = 3,
    parameter int WINDOW_LOG2   = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CHANNELS-1:0] x,
    output logic [31:0]         value [CHANNELS],
    output logic                valid,
    input  logic                ready,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    // valid/ready: value is transferred on any edge where valid && ready; valid then
    // drops on that edge and value is held until the next measurement latches.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;
    localparam state_t START_STATE = (SETTLE_CYCLES > 0) ? SETTLE : ACCUM;

    state_t                 state_q, state_d;
    logic [SW-1:0]          settle_cnt;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [WINDOW_LOG2:0]   ones_cnt  [CHANNELS];
    logic [WINDOW_LOG2:0]   ones_next [CHANNELS];
    logic                   launch;
    logic                   last_sample;

    function automatic logic [31:0] to_value(input logic [WINDOW_LOG2:0] c);
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
        to_value = (32'(c) << 1) - (32'd1 << WINDOW_LOG2);
`else
        to_value = 32'(c);
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        last_sample = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = START_STATE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) state_d = ACCUM;
            end
            ACCUM: begin
                if (win_cnt == WIN_LAST) begin
                    last_sample = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                // A start on the handshake edge chains straight into the next measurement.
                if (ready) begin
                    if (start) begin
                        launch  = 1'b1;
                        state_d = START_STATE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            ones_next[i] = ones_cnt[i] + {{WINDOW_LOG2{1'b0}}, x[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            win_cnt    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                ones_cnt[i] <= '0;
                value[i]    <= '0;
            end
        end else if (launch) begin
            settle_cnt <= '0;
            win_cnt    <= '0;
            for (int i = 0; i < CHANNELS; i++) ones_cnt[i] <= '0;
        end else begin
            if (state_q == SETTLE) settle_cnt <= settle_cnt + SW'(1);
            if (state_q == ACCUM) begin
                win_cnt <= win_cnt + WINDOW_LOG2'(1);
                for (int i = 0; i < CHANNELS; i++) ones_cnt[i] <= ones_next[i];
            end
            // The final sample is folded in directly so the window is exactly 2^W samples.
            if (last_sample) begin
                for (int i = 0; i < CHANNELS; i++) value[i] <= to_value(ones_next[i]);
            end
        end
    end

    assign valid     = (state_q == HOLD);
    assign busy      = (state_q == SETTLE) || (state_q == ACCUM);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bitstream_decoder.sv
// Bench for bitstream_decoder: directed sequence with random bitstreams and a counting model.
module tb_bitstream_decoder;

    localparam int S = 4;
    localparam int W = 8;
    localparam int N = 1 << W;

    logic        clk = 1'b0;
    logic        rst, start, ready, valid, busy;
    logic [2:0]  x;
    logic [31:0] value [3];
    logic [1:0]  dbg_state;

    logic        start_s, ready_s, valid_s, busy_s;
    logic [0:0]  x_s;
    logic [31:0] value_s [1];
    logic [1:0]  dbg_state_s;

    int checks = 0;
    int errors = 0;
    int exp_cnt [3];
    bit seen_valid;

    bitstream_decoder #(.CHANNELS(3), .WINDOW_LOG2(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .value(value),
        .valid(valid), .ready(ready), .busy(busy), .dbg_state(dbg_state)
    );

    bitstream_decoder #(.CHANNELS(1), .WINDOW_LOG2(2), .SETTLE_CYCLES(0)) dut_small (
        .clk(clk), .rst(rst), .start(start_s), .x(x_s), .value(value_s),
        .valid(valid_s), .ready(ready_s), .busy(busy_s), .dbg_state(dbg_state_s)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_value(input int c, input int n);
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
        return 32'(2 * c - n);
`else
        return 32'(c);
`endif
    endfunction

    function automatic logic [2:0] gen_x(input int mode, input int j);
        case (mode)
            0:       return 3'b111;
            1:       return {(j % 4) == 0, 1'b0, (j % 2) == 0};
            default: return 3'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_values(input string tag);
        for (int c = 0; c < 3; c++) check(tag, value[c], exp_value(exp_cnt[c], N));
    endtask

    // One full measurement; when started is set, the start edge E0 has already happened.
    task automatic run_window(input int mode, input bit started);
        logic [2:0] xv;
        if (!started) begin
            start = 1'b1;
            cycle();
            start = 1'b0;
            check_bit("busy_after_start", busy, 1'b1);
        end
        for (int c = 0; c < 3; c++) exp_cnt[c] = 0;
        for (int k = 1; k <= S + N; k++) begin
            if (k <= S) begin
                xv = 3'b111;
            end else begin
                xv = gen_x(mode, k - S - 1);
                for (int c = 0; c < 3; c++) if (xv[c]) exp_cnt[c]++;
            end
            x = xv;
            cycle();
            if (k == S + N - 1) begin
                check_bit("valid_before_last_sample", valid, 1'b0);
                check_bit("busy_before_last_sample", busy, 1'b1);
            end
        end
        check_bit("valid_at_window_end", valid, 1'b1);
        check_bit("busy_at_window_end", busy, 1'b0);
        check_values("value_at_window_end");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0; x = '0;
        start_s = 1'b0; ready_s = 1'b1; x_s = '0;
        #12;
        check_bit("reset_valid", valid, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        for (int c = 0; c < 3; c++) check("reset_value", value[c], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        // All-ones window reaches full scale without wrapping.
        ready = 1'b1;
        run_window(0, 1'b0);
        cycle();
        check_bit("handshake_valid_low", valid, 1'b0);
        check_bit("handshake_busy_low", busy, 1'b0);
        check_values("value_retained_after_handshake");

        // Fixed pattern; settle-phase ones must not be counted.
        run_window(1, 1'b0);
        cycle();
        run_window(2, 1'b0);
        cycle();

        // Consumer stalls in HOLD while start pulses are ignored.
        ready = 1'b0;
        run_window(2, 1'b0);
        for (int i = 0; i < 50; i++) begin
            start = ((i % 7) == 3);
            cycle();
            check_bit("hold_valid_stable", valid, 1'b1);
            check_bit("hold_no_restart", busy, 1'b0);
            check_values("hold_value_stable");
        end
        start = 1'b0;
        ready = 1'b1;
        cycle();
        check_bit("release_valid_low", valid, 1'b0);
        check_bit("release_idle", busy, 1'b0);

        // Back-to-back: start on the handshake edge.
        run_window(2, 1'b0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check_bit("b2b_busy", busy, 1'b1);
        check_bit("b2b_valid_low", valid, 1'b0);
        run_window(2, 1'b1);
        cycle();

        // Asynchronous reset part-way through ACCUM discards the measurement.
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= S + 100; k++) begin
            x = 3'($urandom_range(0, 7));
            cycle();
        end
        #2;
        rst = 1'b1;
        #1;
        check_bit("async_reset_valid", valid, 1'b0);
        check_bit("async_reset_busy", busy, 1'b0);
        for (int c = 0; c < 3; c++) check("async_reset_value", value[c], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (valid !== 1'b0) seen_valid = 1'b1;
        end
        check_bit("no_valid_after_abort", seen_valid, 1'b0);
        run_window(2, 1'b0);
        cycle();

        // Zero settle cycles, 4-sample window: only the first sampled edge carries a one.
        start_s = 1'b1;
        cycle();
        start_s = 1'b0;
        check_bit("small_busy_after_start", busy_s, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            x_s = (k == 1);
            cycle();
            if (k == 3) check_bit("small_valid_before_e4", valid_s, 1'b0);
        end
        check_bit("small_valid_at_e4", valid_s, 1'b1);
        check("small_value_at_e4", value_s[0], exp_value(1, 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
